jc_phase_decoder: RTL and testbench

Downstream consumer of the 64-bit Johnson counter. Each cycle with `en` high, the block samples the counter's thermometer-style state vector and checks that it is a legal Johnson code. It decodes the vector into a binary phase index in 0..2N-1. It also checks that consecutive phases advance by exactly one, and counts full ring revolutions. It lets the rest of the design use the Johnson ring as a phase/timing reference without looking at raw 64-bit state.

---
 rtl/jc_phase_decoder.sv | 178 +++++++++++++++++
 tb/tb_jc_phase_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/jc_phase_decoder.sv
// jc_phase_decoder: validates and decodes a Johnson-counter state vector into
// a binary phase index. It also checks that successive samples advance by one
// phase and counts full ring revolutions.
module jc_phase_decoder #(
  parameter int unsigned N  = 64,
  parameter int unsigned PW = 7,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [N-1:0]  jc_in,
  output logic [PW-1:0] phase,
  output logic          phase_vld,
  output logic          code_err,
  output logic          seq_err,
  output logic          wrap_pulse,
  output logic [CW-1:0] wrap_count,
  output logic          err_sticky
);

  localparam int unsigned CNTW = $clog2(N + 1);

  // Stage-1 sample registers
  logic [N-1:0]  r_jc;
  logic          r_s1_vld;

  // Stage-2 / output registers
  logic [PW-1:0] r_phase;
  logic          r_phase_vld;
  logic          r_code_err;
  logic          r_seq_err;
  logic          r_wrap_pulse;
  logic [CW-1:0] r_wrap_count;
  logic          r_err_sticky;

  // Sequence history
  logic [PW-1:0] r_last_phase;
  logic          r_hist_vld;

  // Combinational decode and next-state values
  logic [CNTW-1:0] w_ones;
  logic [CNTW-1:0] w_trans;
  logic            w_legal;
  logic [PW-1:0]   w_dec_phase;
  logic [PW-1:0]   w_exp_phase;
  logic            w_check;
  logic            w_seq_err;
  logic            w_wrap;

  logic [N-1:0]  w_jc_nx;
  logic          w_s1_vld_nx;
  logic [PW-1:0] w_phase_nx;
  logic          w_phase_vld_nx;
  logic          w_code_err_nx;
  logic          w_seq_err_nx;
  logic          w_wrap_pulse_nx;
  logic [CW-1:0] w_wrap_count_nx;
  logic          w_err_sticky_nx;
  logic [PW-1:0] w_last_phase_nx;
  logic          w_hist_vld_nx;

  // Popcount of the sample and count of adjacent-bit transitions
  always_comb begin
    w_ones  = '0;
    w_trans = '0;
    for (int i = 0; i < N; i++) begin
      w_ones = w_ones + CNTW'(r_jc[i]);
    end
    for (int i = 0; i < N - 1; i++) begin
      w_trans = w_trans + CNTW'(r_jc[i] ^ r_jc[i+1]);
    end
  end

  // Legality, phase decode and sequence/wrap evaluation for the stage-2 sample
  always_comb begin
    w_legal     = (w_trans <= CNTW'(1));
    w_dec_phase = '0;
    if (w_legal) begin
      // Ones packed at the bottom (but not all-ones) are the second half-ring
      if (r_jc[0] && !r_jc[N-1]) begin
        w_dec_phase = PW'(2 * N - 32'(w_ones));
      end else begin
        w_dec_phase = PW'(w_ones);
      end
    end
    w_exp_phase = (r_last_phase == PW'(2 * N - 1)) ? '0 : r_last_phase + PW'(1);
    // A sample completing on a clr edge is treated as the first one
    w_check     = w_legal && r_hist_vld && !clr;
    w_seq_err   = w_check && (w_dec_phase != w_exp_phase);
    w_wrap      = w_check && (r_last_phase == PW'(2 * N - 1)) && (w_dec_phase == '0);
  end

  // Next-state for pipeline, outputs, history and counters
  always_comb begin
    w_jc_nx         = r_jc;
    w_s1_vld_nx     = en;
    w_phase_nx      = r_phase;
    w_phase_vld_nx  = 1'b0;
    w_code_err_nx   = r_code_err;
    w_seq_err_nx    = r_seq_err;
    w_wrap_pulse_nx = 1'b0;
    w_wrap_count_nx = r_wrap_count;
    w_err_sticky_nx = r_err_sticky;
    w_last_phase_nx = r_last_phase;
    w_hist_vld_nx   = r_hist_vld;

    if (en) begin
      w_jc_nx = jc_in;
    end

    if (r_s1_vld) begin
      w_phase_nx      = w_dec_phase;
      w_phase_vld_nx  = 1'b1;
      w_code_err_nx   = !w_legal;
      w_seq_err_nx    = w_seq_err;
      w_wrap_pulse_nx = w_wrap;
      if (w_wrap && (r_wrap_count != '1)) begin
        w_wrap_count_nx = r_wrap_count + CW'(1);
      end
      if (!w_legal || w_seq_err) begin
        w_err_sticky_nx = 1'b1;
      end
      if (w_legal) begin
        w_last_phase_nx = w_dec_phase;
        w_hist_vld_nx   = 1'b1;
      end else begin
        w_hist_vld_nx   = 1'b0;
      end
    end else if (clr) begin
      w_hist_vld_nx = 1'b0;
    end

    if (clr) begin
      w_wrap_count_nx = '0;
      w_err_sticky_nx = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_jc         <= '0;
      r_s1_vld     <= 1'b0;
      r_phase      <= '0;
      r_phase_vld  <= 1'b0;
      r_code_err   <= 1'b0;
      r_seq_err    <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_wrap_count <= '0;
      r_err_sticky <= 1'b0;
      r_last_phase <= '0;
      r_hist_vld   <= 1'b0;
    end else begin
      r_jc         <= w_jc_nx;
      r_s1_vld     <= w_s1_vld_nx;
      r_phase      <= w_phase_nx;
      r_phase_vld  <= w_phase_vld_nx;
      r_code_err   <= w_code_err_nx;
      r_seq_err    <= w_seq_err_nx;
      r_wrap_pulse <= w_wrap_pulse_nx;
      r_wrap_count <= w_wrap_count_nx;
      r_err_sticky <= w_err_sticky_nx;
      r_last_phase <= w_last_phase_nx;
      r_hist_vld   <= w_hist_vld_nx;
    end
  end

  assign phase      = r_phase;
  assign phase_vld  = r_phase_vld;
  assign code_err   = r_code_err;
  assign seq_err    = r_seq_err;
  assign wrap_pulse = r_wrap_pulse;
  assign wrap_count = r_wrap_count;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_jc_phase_decoder.sv
// Scoreboard bench for jc_phase_decoder: expected results are computed from a
// table-based Johnson model when a sample is driven and compared on phase_vld.
module tb_jc_phase_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic [63:0] jc_in;
  logic [6:0]  phase;
  logic        phase_vld;
  logic        code_err;
  logic        seq_err;
  logic        wrap_pulse;
  logic [15:0] wrap_count;
  logic        err_sticky;

  jc_phase_decoder #(.N(64), .PW(7), .CW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .jc_in     (jc_in),
    .phase     (phase),
    .phase_vld (phase_vld),
    .code_err  (code_err),
    .seq_err   (seq_err),
    .wrap_pulse(wrap_pulse),
    .wrap_count(wrap_count),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  ph;
    logic        ce;
    logic        se;
    logic        wp;
    logic        sticky;
    logic [15:0] wc;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit prev_en = 1'b0;

  // Reference model state
  int          m_last;
  bit          m_hist;
  int          m_wc;
  bit          m_sticky;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Legal Johnson code for phase p, built from the sequence definition
  function automatic logic [63:0] jc_code(input int p);
    logic [63:0] ones;
    ones = '1;
    if (p == 0) return 64'd0;
    if (p <= 64) return ones << (64 - p);
    return (64'd1 << (128 - p)) - 64'd1;
  endfunction

  task automatic push_sample(input logic [63:0] v);
    exp_t e;
    int   p;
    p = -1;
    for (int i = 0; i < 128; i++) begin
      if (jc_code(i) == v) p = i;
    end
    e.ce = (p < 0);
    e.se = 1'b0;
    e.wp = 1'b0;
    e.ph = '0;
    if (p >= 0) begin
      e.ph = 7'(p);
      if (m_hist) begin
        e.se = (p != ((m_last + 1) % 128));
        e.wp = (m_last == 127) && (p == 0);
      end
      m_last = p;
      m_hist = 1'b1;
    end else begin
      m_hist = 1'b0;
    end
    if (e.wp && m_wc < 65535) m_wc++;
    if (e.ce || e.se) m_sticky = 1'b1;
    e.sticky = m_sticky;
    e.wc     = 16'(m_wc);
    sb.push_back(e);
  endtask

  task automatic step(input bit e, input logic [63:0] v, input bit c);
    exp_t x;
    en    = e;
    jc_in = v;
    clr   = c;
    if (e) push_sample(v);
    if (c) begin
      m_hist   = 1'b0;
      m_wc     = 0;
      m_sticky = 1'b0;
    end
    @(posedge clk);
    #1;
    check("phase_vld", 64'(phase_vld), 64'(prev_en));
    prev_en = e;
    if (phase_vld) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        x = sb.pop_front();
        check("phase", 64'(phase), 64'(x.ph));
        check("code_err", 64'(code_err), 64'(x.ce));
        check("seq_err", 64'(seq_err), 64'(x.se));
        check("wrap_pulse", 64'(wrap_pulse), 64'(x.wp));
        check("err_sticky", 64'(err_sticky), 64'(x.sticky));
        check("wrap_count", 64'(wrap_count), 64'(x.wc));
      end
    end else begin
      check("wrap_pulse_idle", 64'(wrap_pulse), 64'd0);
    end
    en  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"}, 64'(phase), 64'd0);
    check({tag, "_vld"}, 64'(phase_vld), 64'd0);
    check({tag, "_code_err"}, 64'(code_err), 64'd0);
    check({tag, "_seq_err"}, 64'(seq_err), 64'd0);
    check({tag, "_wrap_pulse"}, 64'(wrap_pulse), 64'd0);
    check({tag, "_wrap_count"}, 64'(wrap_count), 64'd0);
    check({tag, "_sticky"}, 64'(err_sticky), 64'd0);
  endtask

  // Reset asserted mid-cycle; outputs must clear without a clock edge
  task automatic mid_reset();
    #3;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    check_all_zero("rst_async");
    sb.delete();
    prev_en  = 1'b0;
    m_hist   = 1'b0;
    m_wc     = 0;
    m_sticky = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    rst = 1'b1; en = 1'b0; clr = 1'b0; jc_in = '0;
    m_last = 0; m_hist = 1'b0; m_wc = 0; m_sticky = 1'b0;
    #2;
    check_all_zero("init");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 64'd0, 1'b0);

    // Full revolution plus a bit, driven by a Johnson counter model
    v = '0;
    for (int i = 0; i < 140; i++) begin
      step(1'b1, v, 1'b0);
      v = {~v[0], v[63:1]};
    end
    step(1'b0, 64'd0, 1'b0);
    check("ring_wrap_count", 64'(wrap_count), 64'd1);
    check("ring_sticky", 64'(err_sticky), 64'd0);

    // Spot decodes (non-consecutive, so sequence errors are expected)
    step(1'b0, 64'd0, 1'b1);
    step(1'b1, 64'hFFFFF000_00000000, 1'b0);
    step(1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    step(1'b1, 64'h7FFFFFFF_FFFFFFFF, 1'b0);
    step(1'b1, 64'h00000000_00000001, 1'b0);
    step(1'b0, 64'd0, 1'b0);
    check("spot_last_phase", 64'(phase), 64'd127);

    // Illegal code breaks history; next legal sample unchecked
    step(1'b0, 64'd0, 1'b1);
    check("clr_sticky", 64'(err_sticky), 64'd0);
    step(1'b1, 64'hF0F0F0F0_F0F0F0F0, 1'b0);
    step(1'b1, jc_code(30), 1'b0);
    step(1'b0, 64'd0, 1'b0);
    check("after_illegal_phase", 64'(phase), 64'd30);
    check("after_illegal_seq", 64'(seq_err), 64'd0);
    check("after_illegal_sticky", 64'(err_sticky), 64'd1);

    // Skipped phase flags seq_err; sticky holds until clr
    step(1'b0, 64'd0, 1'b1);
    step(1'b1, jc_code(10), 1'b0);
    step(1'b1, jc_code(12), 1'b0);
    step(1'b0, 64'd0, 1'b0);
    check("skip_seq_err", 64'(seq_err), 64'd1);
    step(1'b0, 64'd0, 1'b0);
    check("skip_sticky_hold", 64'(err_sticky), 64'd1);
    step(1'b0, 64'd0, 1'b1);
    check("skip_sticky_clr", 64'(err_sticky), 64'd0);

    // Reset while streaming at phase 90
    for (int p = 0; p <= 90; p++) step(1'b1, jc_code(p), 1'b0);
    mid_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 64'd0, 1'b0);
    step(1'b1, jc_code(50), 1'b0);
    step(1'b1, jc_code(51), 1'b0);
    step(1'b0, 64'd0, 1'b0);
    check("post_rst_seq", 64'(seq_err), 64'd0);
    check("post_rst_wrap_count", 64'(wrap_count), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
